// File: rtl/aes_cmd_regfile_pkg.sv
// aes_cmd_pkg: shared constants for the AES command register file.
//   - byte offsets inside the 64-byte register window
//   - engine-tracking state enum
//   - STATUS register bit positions
package aes_cmd_pkg;

  localparam logic [5:0] OFF_START  = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_ADDR   = 6'h02;  // 0x02..0x03, little-endian
  localparam logic [5:0] OFF_LEN    = 6'h04;  // 0x04..0x05, little-endian
  localparam logic [5:0] OFF_KEY    = 6'h10;  // 0x10..0x1F
  localparam logic [5:0] OFF_CTR    = 6'h20;  // 0x20..0x2F

  localparam int STS_BUSY = 0;
  localparam int STS_ERR  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/aes_cmd_regfile_if.sv
// aes_cmd_regfile_if: byte-wide strobe bus into the AES command register file.
//   stb      request valid (one cycle)
//   wr       1 = write, 0 = read
//   addr     byte address
//   data_in  write data
//   data_out registered read data, valid with ack
//   ack      completion, one cycle after stb
interface aes_cmd_regfile_if;
  logic        stb;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ack;

  modport master (output stb, wr, addr, data_in, input data_out, ack);
  modport slave  (input stb, wr, addr, data_in, output data_out, ack);
endinterface

// File: rtl/aes_cmd_regfile_byte_bank.sv
// aes_byte_bank: KEY_BYTES x 8 register array, byte write enable, async read mux.
//   clk, rst   clock, async active-low reset (clears all bytes)
//   we/waddr/wdata  single-byte write port
//   raddr/rdata     combinational byte read
//   q          flat view, byte i at q[8i+7:8i]
module aes_byte_bank #(
  parameter  int KEY_BYTES = 16,
  localparam int IDX_W     = $clog2(KEY_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  logic [7:0]             wdata,
  input  logic [IDX_W-1:0]       raddr,
  output logic [7:0]             rdata,
  output logic [8*KEY_BYTES-1:0] q
);
  logic [KEY_BYTES-1:0][7:0] mem;

  for (genvar g = 0; g < KEY_BYTES; g++) begin : g_byte
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                           mem[g] <= '0;
      else if (we && waddr == IDX_W'(g))  mem[g] <= wdata;
    end
  end

  assign rdata = mem[raddr];
  assign q     = mem;
endmodule

// File: rtl/aes_cmd_regfile.sv
// aes_cmd_regfile: memory-mapped command registers for the AES engine.
//   clk, rst     clock, async active-low reset
//   bus          strobe bus (slave side): stb/wr/addr/data_in -> data_out/ack
//   start        one-cycle engine kick, concurrent with the ack of the START write
//   engine_done  one-cycle completion pulse from the engine
//   aes_addr/aes_len/aes_key/aes_ctr  architectural register contents
//   busy         operation in flight
// Optional: define AES_CMD_ERR_EN for a sticky, read-to-clear STATUS[7] error
// flag (unmapped write, write while busy, read of START).
module aes_cmd_regfile
  import aes_cmd_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hff00,
  parameter int          KEY_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_cmd_regfile_if.slave       bus,
  output logic                   start,
  input  logic                   engine_done,
  output logic [15:0]            aes_addr,
  output logic [15:0]            aes_len,
  output logic [8*KEY_BYTES-1:0] aes_key,
  output logic [8*KEY_BYTES-1:0] aes_ctr,
  output logic                   busy
);
  localparam int IDX_W = $clog2(KEY_BYTES);

  state_e state_q, state_d;
  logic   start_d;

  // Window decode: window is 64-byte aligned relative to BASE_ADDR.
  logic [15:0] rel;
  logic [5:0]  off;
  logic        in_win;
  logic        hit_start, hit_status, hit_addr, hit_len, hit_key, hit_ctr;
  logic        wr_en;

  assign rel        = bus.addr - BASE_ADDR;
  assign off        = rel[5:0];
  assign in_win     = (rel[15:6] == '0);
  assign hit_start  = in_win && off == OFF_START;
  assign hit_status = in_win && off == OFF_STATUS;
  assign hit_addr   = in_win && off[5:1] == OFF_ADDR[5:1];
  assign hit_len    = in_win && off[5:1] == OFF_LEN[5:1];
  assign hit_key    = in_win && off >= OFF_KEY && off < OFF_KEY + 6'(KEY_BYTES);
  assign hit_ctr    = in_win && off >= OFF_CTR && off < OFF_CTR + 6'(KEY_BYTES);

  // Every write is dropped while the engine owns the registers.
  assign wr_en = bus.stb && bus.wr && state_q == IDLE;
  assign busy  = (state_q == BUSY);

  logic [7:0] key_rdata, ctr_rdata;

  aes_byte_bank #(.KEY_BYTES(KEY_BYTES)) u_key (
    .clk(clk), .rst(rst), .we(wr_en && hit_key), .waddr(off[IDX_W-1:0]),
    .wdata(bus.data_in), .raddr(off[IDX_W-1:0]), .rdata(key_rdata), .q(aes_key)
  );

  aes_byte_bank #(.KEY_BYTES(KEY_BYTES)) u_ctr (
    .clk(clk), .rst(rst), .we(wr_en && hit_ctr), .waddr(off[IDX_W-1:0]),
    .wdata(bus.data_in), .raddr(off[IDX_W-1:0]), .rdata(ctr_rdata), .q(aes_ctr)
  );

  // Sticky error flag
  logic [7:0] sts;
`ifdef AES_CMD_ERR_EN
  logic err_q, err_set, err_clr, mapped;
  // STATUS writes are legal (mapped) but have no effect.
  assign mapped  = hit_start | hit_status | hit_addr | hit_len | hit_key | hit_ctr;
  assign err_set = bus.stb && ((bus.wr && (state_q == BUSY || !mapped)) ||
                               (!bus.wr && hit_start));
  assign err_clr = bus.stb && !bus.wr && hit_status;

  // Set wins over a coincident clearing read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_set | (err_q & ~err_clr);
  end

  always_comb begin
    sts           = '0;
    sts[STS_BUSY] = busy;
    sts[STS_ERR]  = err_q;
  end
`else
  always_comb begin
    sts           = '0;
    sts[STS_BUSY] = busy;
  end
`endif

  // Read mux; data_out is forced to 0 in cycles without a read.
  logic [7:0] rd_d;
  always_comb begin
    rd_d = '0;
    if (bus.stb && !bus.wr) begin
      if (hit_status)   rd_d = sts;
      else if (hit_addr) rd_d = off[0] ? aes_addr[15:8] : aes_addr[7:0];
      else if (hit_len)  rd_d = off[0] ? aes_len[15:8]  : aes_len[7:0];
      else if (hit_key)  rd_d = key_rdata;
      else if (hit_ctr)  rd_d = ctr_rdata;
    end
  end

  // Engine tracking FSM
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: if (wr_en && hit_start && bus.data_in[0]) begin
              state_d = BUSY;
              start_d = 1'b1;
            end
      BUSY: if (engine_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      start        <= 1'b0;
      bus.ack      <= 1'b0;
      bus.data_out <= '0;
      aes_addr     <= '0;
      aes_len      <= '0;
    end else begin
      state_q      <= state_d;
      start        <= start_d;
      bus.ack      <= bus.stb;
      bus.data_out <= rd_d;
      if (wr_en && hit_addr) begin
        if (off[0]) aes_addr[15:8] <= bus.data_in;
        else        aes_addr[7:0]  <= bus.data_in;
      end
      if (wr_en && hit_len) begin
        if (off[0]) aes_len[15:8] <= bus.data_in;
        else        aes_len[7:0]  <= bus.data_in;
      end
    end
  end
endmodule

// File: doc/aes_cmd_regfile.md
Name: aes_cmd_regfile

Overview:
- Memory-mapped command register file for the AES accelerator; sits directly downstream of the command decode stage.
- Consumes bus strobes (addr/data_in/wr/stb) and holds the architectural registers: DMA address, length, key, counter, status.
- Issues a single-cycle start pulse to the encryption engine and tracks busy/idle.
- Returns registered read data with a one-cycle ack.

Parameters:
- BASE_ADDR, 16'hff00, base of the 64-byte register window.
- KEY_BYTES, 16, byte count of the key and counter registers (128 bits each).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stb  in  1  bus request valid for one cycle.
- wr  in  1  1 = write, 0 = read; sampled with stb.
- addr  in  16  byte address.
- data_in  in  8  write data.
- data_out  out  8  read data; valid when ack=1.
- ack  out  1  request completion, one cycle after stb.
- start  out  1  one-cycle pulse to the engine.
- engine_done  in  1  one-cycle completion pulse from the engine.
- aes_addr  out  16  DMA base address register.
- aes_len  out  16  DMA length register.
- aes_key  out  128  key register.
- aes_ctr  out  128  counter register.
- busy  out  1  1 while an operation is in flight.

Behaviour:
- Reset (rst=0, asynchronous): all outputs and registers are 0; state IDLE.
- Address map, offsets from BASE_ADDR:
  - 0x00: START, write-only; a read returns 0.
  - 0x01: STATUS, read-only; bit0 = busy, bits 7:1 = 0.
  - 0x02–0x03: aes_addr, little-endian (0x02 is the low byte).
  - 0x04–0x05: aes_len, little-endian.
  - 0x10–0x1F: aes_key; byte i maps to aes_key[8i+7:8i].
  - 0x20–0x2F: aes_ctr; same byte mapping as the key.
  - Any other offset is unmapped: reads return 0x00, writes are dropped.
- Handshake:
  - Every stb produces ack=1 exactly one cycle later; ack is never asserted without a preceding stb.
  - Back-to-back stb on consecutive cycles is legal; each gets its own ack.
  - data_out is registered; it is 0 in cycles without ack.
- Writes take effect at the clock edge that samples stb; a read in the following cycle returns the new value.
- FSM IDLE/BUSY:
  - IDLE -> BUSY on a write to START with data_in[0]=1; start=1 for that one cycle (registered, concurrent with ack). A START write with data_in[0]=0 is ignored.
  - BUSY -> IDLE on engine_done=1.
  - While BUSY, all writes are dropped and start is never asserted; reads are always served.
  - engine_done while IDLE is ignored.
  - engine_done and a START write in the same cycle while BUSY: transition to IDLE; the START write is dropped (no start pulse).
- busy = (state==BUSY); it rises in the cycle start is asserted.
- Reset asserted mid-operation: immediate return to IDLE, registers cleared, no start pulse; any pending ack is lost.

Optional Feature:
- Macro: AES_CMD_ERR_EN.
- When defined:
  - STATUS bit7 is a sticky error flag, set by a write to an unmapped offset, a write while BUSY, or a read of START.
  - Reading STATUS returns the flag and clears it in the same cycle.
  - If a new error and the clearing read coincide, the flag stays set.
- When undefined: the flag logic is absent; bit7 reads 0; illegal accesses are silently dropped.

Decomposition:
- Shared package aes_cmd_pkg holds:
  - offset constants: OFF_START, OFF_STATUS, OFF_ADDR, OFF_LEN, OFF_KEY, OFF_CTR;
  - the state enum {IDLE, BUSY};
  - the STATUS bit positions (STS_BUSY=0, STS_ERR=7).
- One sub-module, aes_byte_bank: a KEY_BYTES x 8 register array with byte write-enable and read mux, instantiated twice (key, counter).

Test Plan:
- Write 0x34 @0xff02, 0x12 @0xff03; read 0xff02, 0xff03 -> aes_addr=0x1234, reads return 0x34 and 0x12, each ack exactly one cycle after its stb.
- Write 0x00..0x0F to 0xff10..0xff1F back-to-back -> aes_key=128'h0f0e...0100; 16 acks on consecutive cycles.
- Write 0x01 @0xff00 -> start pulses one cycle, busy=1, STATUS reads 0x01; write 0x55 @0xff04 while busy -> aes_len unchanged at 0; engine_done -> busy=0, STATUS reads 0x00.
- While BUSY, START write and engine_done in the same cycle -> busy=0, no start pulse; write 0x01 @0xff00 next -> start pulses.
- rst=0 asserted mid-BUSY with key loaded -> busy, key, ctr, ack all 0 immediately; after release, STATUS reads 0x00.
- With AES_CMD_ERR_EN: write @0xff40 -> STATUS reads 0x80, then a second read returns 0x00; without the macro, STATUS reads 0x00 after the same write.
